pipeline_regfile: RTL and testbench



---
 rtl/pipeline_regfile_if.sv | 31 +++
 rtl/pipeline_regfile.sv | 81 ++++++++
 tb/tb_pipeline_regfile.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_regfile_if.sv
// Write-back / decode / debug port bundle for the architectural register file.
// The master side belongs to the pipeline (WB commits and ID reads).
// The slave side belongs to the register file.
interface pipeline_regfile_if #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int AW      = $clog2(REG_NUM)
);
    logic            RegWrite_WB;
    logic [AW-1:0]   rd_addr_WB;
    logic [XLEN-1:0] rd_data_WB;
    logic [AW-1:0]   rs1_addr_ID;
    logic [AW-1:0]   rs2_addr_ID;
    logic [XLEN-1:0] rs1_data_ID;
    logic [XLEN-1:0] rs2_data_ID;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [31:0]     wr_count;

    modport master (
        output RegWrite_WB, rd_addr_WB, rd_data_WB,
        output rs1_addr_ID, rs2_addr_ID, dbg_addr,
        input  rs1_data_ID, rs2_data_ID, dbg_data, wr_count
    );

    modport slave (
        input  RegWrite_WB, rd_addr_WB, rd_data_WB,
        input  rs1_addr_ID, rs2_addr_ID, dbg_addr,
        output rs1_data_ID, rs2_data_ID, dbg_data, wr_count
    );
endinterface

// File: rtl/pipeline_regfile.sv
// Architectural integer register file.
// - x0 is hardwired to zero and has no storage.
// - WB commits on the rising clock edge.
// - ID gets two combinational read ports, and there is one debug read port.
// - wr_count counts committed writes and wraps modulo 2^32.
// Optional feature: define REGFILE_WB_BYPASS_EN to forward the write-back data
// straight to the ID read ports when a same-cycle commit targets the register
// being read. The debug port never uses the bypass.
module pipeline_regfile #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_regfile_if.slave   bus
);
    localparam int AW = $clog2(REG_NUM);

    logic [XLEN-1:0] regs [1:REG_NUM-1];
    logic [31:0]     wr_count_q;
    logic            commit;

    // Indices at or above REG_NUM only exist when REG_NUM is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < REG_NUM;
    endfunction

    // Stored value as seen by a read port: zero for x0 and for unmapped indices.
    function automatic logic [XLEN-1:0] stored(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != '0 && in_range(a)) begin
            v = regs[a];
        end
        return v;
    endfunction

    // A write only takes effect for a real, mapped, nonzero register outside reset.
    always_comb begin
        commit = !rst && bus.RegWrite_WB && bus.rd_addr_WB != '0 && in_range(bus.rd_addr_WB);
    end

    // Storage and write counter.
    // Reset wins over a simultaneous commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (commit) begin
            regs[bus.rd_addr_WB] <= bus.rd_data_WB;
            wr_count_q           <= wr_count_q + 32'd1;
        end
    end

    // ID read ports.
    // With the bypass enabled, an in-flight commit to the same register is
    // forwarded. commit already excludes x0, unmapped indices and reset.
    always_comb begin
        bus.rs1_data_ID = stored(bus.rs1_addr_ID);
        bus.rs2_data_ID = stored(bus.rs2_addr_ID);
`ifdef REGFILE_WB_BYPASS_EN
        if (commit && bus.rs1_addr_ID == bus.rd_addr_WB) begin
            bus.rs1_data_ID = bus.rd_data_WB;
        end
        if (commit && bus.rs2_addr_ID == bus.rd_addr_WB) begin
            bus.rs2_data_ID = bus.rd_data_WB;
        end
`else
        // Without the bypass a same-cycle read returns the old value.
        // The hazard unit inserts the stall.
`endif
    end

    // Debug port and counter always reflect committed storage only.
    always_comb begin
        bus.dbg_data = stored(bus.dbg_addr);
        bus.wr_count = wr_count_q;
    end
endmodule

// File: tb/tb_pipeline_regfile.sv
// Directed, table-driven testbench for pipeline_regfile.
// Expected values are hand-computed.
// The bypass-dependent ones follow REGFILE_WB_BYPASS_EN.
module tb_pipeline_regfile;
    localparam int XLEN    = 32;
    localparam int REG_NUM = 32;
    localparam int AW      = 5;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pipeline_regfile_if #(.XLEN(XLEN), .REG_NUM(REG_NUM)) bus ();

    pipeline_regfile #(.XLEN(XLEN), .REG_NUM(REG_NUM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic            we;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] d;
        logic [AW-1:0]   a1;
        logic [AW-1:0]   a2;
        logic [AW-1:0]   ad;
        logic [XLEN-1:0] e1;
        logic [XLEN-1:0] e2;
        logic [XLEN-1:0] ed;
        logic [31:0]     ec;
    } vec_t;

    vec_t vecs [13];

    task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] rd,
                                 input logic [XLEN-1:0] d, input logic [AW-1:0] a1,
                                 input logic [AW-1:0] a2, input logic [AW-1:0] ad);
        rst                 = r;
        bus.RegWrite_WB     = we;
        bus.rd_addr_WB      = rd;
        bus.rd_data_WB      = d;
        bus.rs1_addr_ID     = a1;
        bus.rs2_addr_ID     = a2;
        bus.dbg_addr        = ad;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] ed, input logic [31:0] ec);
        checkOutput({tag, " rs1"}, bus.rs1_data_ID, e1);
        checkOutput({tag, " rs2"}, bus.rs2_data_ID, e2);
        checkOutput({tag, " dbg"}, bus.dbg_data, ed);
        checkOutput({tag, " cnt"}, bus.wr_count, ec);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Each row: drive after negedge, check combinational outputs, commit at posedge.
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 5'd5,  32'h0, 32'h0, 32'h0, 32'd0};
        vecs[1]  = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  5'd0,  5'd3,
                     BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'h0, 32'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  5'd3,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  5'd0,
                     32'h0, 32'hDEADBEEF, 32'h0, 32'd1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'd1};
        vecs[5]  = '{1'b1, 5'd7,  32'h11,       5'd3,  5'd7,  5'd7,
                     32'hDEADBEEF, BYP ? 32'h11 : 32'h0, 32'h0, 32'd1};
        vecs[6]  = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd7,  5'd7,
                     BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 32'h11, 32'd2};
        vecs[7]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd7,  5'd31, 5'd7,
                     32'h22, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h22, 32'd3};
        vecs[8]  = '{1'b0, 5'd31, 32'h12345678, 5'd31, 5'd7,  5'd31,
                     32'hA5A5A5A5, 32'h22, 32'hA5A5A5A5, 32'd4};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 5'd31,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd4};
        vecs[10] = '{1'b1, 5'd1,  32'h1,        5'd1,  5'd2,  5'd1,
                     BYP ? 32'h1 : 32'h0, 32'h0, 32'h0, 32'd4};
        vecs[11] = '{1'b1, 5'd2,  32'hCAFEF00D, 5'd1,  5'd2,  5'd2,
                     32'h1, BYP ? 32'hCAFEF00D : 32'h0, 32'h0, 32'd5};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd1,  5'd3,
                     32'hCAFEF00D, 32'h1, 32'hDEADBEEF, 32'd6};

        // Power-on reset.
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (i != 0) @(negedge clk);
            applyStimulus(1'b0, vecs[i].we, vecs[i].rd, vecs[i].d, vecs[i].a1, vecs[i].a2, vecs[i].ad);
            #1;
            checkAll($sformatf("v%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].ed, vecs[i].ec);
        end

        // Reset collides with a commit.
        // The bypass is suppressed, and the write is lost along with all state.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd3, 5'd9);
        #1;
        checkAll("rstwr during", 32'h0, 32'hDEADBEEF, 32'h0, 32'd6);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 5'd31);
        #1;
        checkAll("rstwr after", 32'h0, 32'h0, 32'h0, 32'd0);

        // Write x5, then a one-cycle reset clears it.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 5'd5, 32'h1234, 5'd0, 5'd0, 5'd5);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        #1;
        checkAll("x5 written", 32'h1234, 32'h1234, 32'h1234, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll("x5 reset", 32'h0, 32'h0, 32'h0, 32'd0);

        // Counter wrap: preload near the top, then commit twice.
        @(negedge clk);
        dut.wr_count_q = 32'hFFFF_FFFE;
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h77, 5'd1, 5'd0, 5'd1);
        #1;
        checkOutput("wrap preload cnt", bus.wr_count, 32'hFFFF_FFFE);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 5'd1, 32'h88, 5'd0, 5'd0, 5'd1);
        #1;
        checkAll("wrap max", 32'h0, 32'h0, 32'h77, 32'hFFFF_FFFF);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 5'd1);
        #1;
        checkAll("wrap zero", 32'h88, 32'h0, 32'h88, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
